// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin tie break
// and a per-transfer ack watchdog that answers a stalled strobe with err.
module wb_arbiter_2m #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned SEL_W   = DW / 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   // master 0 (instruction fetch)
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic [AW-1:0]    m0_adr_i,
   input  logic [DW-1:0]    m0_dat_i,
   output logic [DW-1:0]    m0_dat_o,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   // master 1 (load/store unit)
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic [AW-1:0]    m1_adr_i,
   input  logic [DW-1:0]    m1_dat_i,
   output logic [DW-1:0]    m1_dat_o,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   // shared slave
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic [AW-1:0]    s_adr_o,
   output logic [DW-1:0]    s_dat_o,
   input  logic [DW-1:0]    s_dat_i,
   input  logic             s_ack_i,
   output logic [1:0]       gnt_o
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t        state, state_d;
   logic          last_gnt, last_gnt_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          gnt_stb;
   logic          wd_hit;

   // State, round-robin history and watchdog registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         cnt      <= '0;
      end else begin
         state    <= state_d;
         last_gnt <= last_gnt_d;
         cnt      <= cnt_d;
      end
   end

   // Next-state: grant is held for the whole bus cycle, hand-over is direct
   always_comb begin
      state_d    = state;
      last_gnt_d = last_gnt;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = last_gnt ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_d = GNT0;
            else if (m1_cyc_i)        state_d = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_gnt_d = 1'b0;
               state_d    = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_gnt_d = 1'b1;
               state_d    = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Watchdog: counts unacked strobe cycles; a same-cycle ack beats the timeout
   always_comb begin
      gnt_stb = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);
      wd_hit  = (TIMEOUT != 0) && gnt_stb && !s_ack_i && (cnt == LIMIT);
      if ((TIMEOUT == 0) || (state_d != state) || !gnt_stb || s_ack_i || wd_hit)
         cnt_d = '0;
      else
         cnt_d = cnt + CW'(1);
   end

   // Slave mux and per-master responses, all decoded from the current grant
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      gnt_o    = {state == GNT1, state == GNT0};
      case (state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = wd_hit;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = wd_hit;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: a directed vector table for the basic
// grant/mux/ack path plus hand sequences for arbitration, watchdog and reset.
module tb_wb_arbiter_2m;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
   logic        m0_ack_o, m0_err_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
   logic        m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_ack_i;
   logic [1:0]  gnt_o;

   int total = 0;
   int bad   = 0;

   wb_arbiter_2m dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        c0, s0, w0, c1, s1, w1, ack;
      logic [31:0] sdat;
      logic [1:0]  gnt;
      logic        scyc, sstb, swe;
      logic [1:0]  msel;   // 0: slave bus idle, 1: carries m0 payload, 2: m1
      logic        a0, a1;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs checked 2 units later
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
      m0_sel_i = 4'hF; m0_adr_i = 32'h0000_0010; m0_dat_i = 32'h1111_0000;
      m1_sel_i = 4'h3; m1_adr_i = 32'h0000_0100; m1_dat_i = 32'h2222_0000;
      s_dat_i  = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   function automatic vec_t mk(input logic [6:0] in, input logic [31:0] sdat,
                               input logic [1:0] gnt, input logic [2:0] sc,
                               input logic [1:0] msel, input logic [1:0] acks);
      vec_t v;
      {v.c0, v.s0, v.w0, v.c1, v.s1, v.w1, v.ack} = in;
      v.sdat = sdat;
      v.gnt  = gnt;
      {v.scyc, v.sstb, v.swe} = sc;
      v.msel = msel;
      {v.a1, v.a0} = acks;
      return v;
   endfunction

   initial begin
      // inputs {c0,s0,w0,c1,s1,w1,ack}, s_dat, gnt, {scyc,sstb,swe}, payload, {a1,a0}
      vt[0]  = mk(7'b000_000_0, 32'h0,         2'b00, 3'b000, 2'd0, 2'b00);
      vt[1]  = mk(7'b110_000_0, 32'h0,         2'b00, 3'b000, 2'd0, 2'b00);
      vt[2]  = mk(7'b110_000_0, 32'h0,         2'b01, 3'b110, 2'd1, 2'b00);
      vt[3]  = mk(7'b110_000_1, 32'hDEADBEEF,  2'b01, 3'b110, 2'd1, 2'b01);
      vt[4]  = mk(7'b000_000_0, 32'h0,         2'b01, 3'b000, 2'd1, 2'b00);
      vt[5]  = mk(7'b000_111_0, 32'h0,         2'b00, 3'b000, 2'd0, 2'b00);
      vt[6]  = mk(7'b000_111_0, 32'h0,         2'b10, 3'b111, 2'd2, 2'b00);
      vt[7]  = mk(7'b110_111_1, 32'hCAFE0001,  2'b10, 3'b111, 2'd2, 2'b10);
      vt[8]  = mk(7'b110_000_0, 32'h0,         2'b10, 3'b000, 2'd2, 2'b00);
      vt[9]  = mk(7'b110_000_0, 32'h0,         2'b01, 3'b110, 2'd1, 2'b00);
      vt[10] = mk(7'b110_000_1, 32'h1234_5678, 2'b01, 3'b110, 2'd1, 2'b01);
      vt[11] = mk(7'b000_000_0, 32'h0,         2'b01, 3'b000, 2'd1, 2'b00);
      vt[12] = mk(7'b000_000_0, 32'h0,         2'b00, 3'b000, 2'd0, 2'b00);

      do_reset();

      // Table: single m0 read, m1 write, direct hand-over m1 -> m0
      for (int i = 0; i < 13; i++) begin
         {m0_cyc_i, m0_stb_i, m0_we_i} = {vt[i].c0, vt[i].s0, vt[i].w0};
         {m1_cyc_i, m1_stb_i, m1_we_i} = {vt[i].c1, vt[i].s1, vt[i].w1};
         s_ack_i = vt[i].ack;
         s_dat_i = vt[i].sdat;
         settle();
         chk($sformatf("v%0d gnt", i),    32'(gnt_o),    32'(vt[i].gnt));
         chk($sformatf("v%0d s_cyc", i),  32'(s_cyc_o),  32'(vt[i].scyc));
         chk($sformatf("v%0d s_stb", i),  32'(s_stb_o),  32'(vt[i].sstb));
         chk($sformatf("v%0d s_we", i),   32'(s_we_o),   32'(vt[i].swe));
         chk($sformatf("v%0d s_adr", i),  s_adr_o,
             (vt[i].msel == 2'd1) ? 32'h10 : (vt[i].msel == 2'd2) ? 32'h100 : 32'h0);
         chk($sformatf("v%0d s_dat", i),  s_dat_o,
             (vt[i].msel == 2'd1) ? 32'h1111_0000 : (vt[i].msel == 2'd2) ? 32'h2222_0000 : 32'h0);
         chk($sformatf("v%0d s_sel", i),  32'(s_sel_o),
             (vt[i].msel == 2'd1) ? 32'hF : (vt[i].msel == 2'd2) ? 32'h3 : 32'h0);
         chk($sformatf("v%0d m0_ack", i), 32'(m0_ack_o), 32'(vt[i].a0));
         chk($sformatf("v%0d m1_ack", i), 32'(m1_ack_o), 32'(vt[i].a1));
         chk($sformatf("v%0d m0_dat", i), m0_dat_o, vt[i].sdat);
         chk($sformatf("v%0d m1_dat", i), m1_dat_o, vt[i].sdat);
         chk($sformatf("v%0d errs", i),   32'({m1_err_o, m0_err_o}), 32'h0);
         step();
      end

      // Simultaneous request after reset: m0 first, then direct hand-over to m1
      do_reset();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = 4'b1111;
      settle(); chk("tie idle gnt", 32'(gnt_o), 32'h0);
      step();
      s_ack_i = 1'b1;
      settle();
      chk("tie first gnt", 32'(gnt_o), 32'h1);
      chk("tie m0 ack", 32'(m0_ack_o), 32'h1);
      chk("tie m1 no ack", 32'(m1_ack_o), 32'h0);
      step();
      {m0_cyc_i, m0_stb_i, s_ack_i} = 3'b000;
      settle(); chk("tie m0 drop gnt", 32'(gnt_o), 32'h1);
      step();
      s_ack_i = 1'b1;
      settle();
      chk("handover gnt", 32'(gnt_o), 32'h2);
      chk("handover m1 ack", 32'(m1_ack_o), 32'h1);
      chk("handover s_adr", s_adr_o, 32'h100);
      step();
      {m1_cyc_i, m1_stb_i, s_ack_i} = 3'b000;
      settle(); chk("m1 drop gnt", 32'(gnt_o), 32'h2);
      step();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = 4'b1111;
      settle(); chk("retie idle gnt", 32'(gnt_o), 32'h0);
      step();
      settle(); chk("retie m0 wins", 32'(gnt_o), 32'h1);
      step();
      idle_inputs();
      step();

      // m1 burst of three writes while m0 waits for the bus
      {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b111;
      m1_sel_i = 4'hF;
      step();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m1_adr_i = 32'h100 + 32'(4 * k);
         m1_dat_i = 32'hA000_0000 + 32'(k);
         s_ack_i  = 1'b0;
         settle();
         chk($sformatf("burst%0d gnt", k), 32'(gnt_o), 32'h2);
         chk($sformatf("burst%0d adr", k), s_adr_o, 32'h100 + 32'(4 * k));
         chk($sformatf("burst%0d dat", k), s_dat_o, 32'hA000_0000 + 32'(k));
         chk($sformatf("burst%0d we/sel", k), 32'({s_we_o, s_sel_o}), 32'h1F);
         step();
         s_ack_i = 1'b1;
         settle();
         chk($sformatf("burst%0d m1 ack", k), 32'(m1_ack_o), 32'h1);
         chk($sformatf("burst%0d m0 no ack", k), 32'(m0_ack_o), 32'h0);
         step();
      end
      {m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = 4'b0000;
      settle(); chk("burst end gnt", 32'(gnt_o), 32'h2);
      step();
      settle(); chk("burst m0 granted", 32'(gnt_o), 32'h1);
      step();

      // Watchdog: m1 strobe never acked, err exactly on the 16th waiting cycle
      do_reset();
      {m1_cyc_i, m1_stb_i} = 2'b11;
      step();
      for (int g = 1; g <= 20; g++) begin
         settle();
         chk($sformatf("wd g%0d m1_err", g), 32'(m1_err_o), 32'(g == 16));
         chk($sformatf("wd g%0d gnt", g), 32'({m1_ack_o, m0_err_o, gnt_o}), 32'h2);
         step();
      end
      {m1_cyc_i, m1_stb_i} = 2'b00;
      settle(); chk("wd release gnt", 32'(gnt_o), 32'h2);
      step();
      settle(); chk("wd idle gnt", 32'(gnt_o), 32'h0);

      // Async reset in the middle of an m0 transfer
      {m0_cyc_i, m0_stb_i} = 2'b11;
      step(); step();
      for (int g = 0; g < 8; g++) step();
      settle(); chk("pre-reset gnt", 32'(gnt_o), 32'h1);
      s_ack_i = 1'b1;
      rst_i = 1'b1;
      #1;
      chk("async rst gnt", 32'(gnt_o), 32'h0);
      chk("async rst s_cyc", 32'(s_cyc_o), 32'h0);
      chk("async rst m0_ack", 32'(m0_ack_o), 32'h0);
      step();
      rst_i = 1'b0;
      idle_inputs();
      {m1_cyc_i, m1_stb_i} = 2'b11;
      settle(); chk("post-rst idle", 32'(gnt_o), 32'h0);
      step();
      for (int g = 1; g <= 16; g++) begin
         settle();
         chk($sformatf("post-rst g%0d", g), 32'({m1_err_o, gnt_o}), (g == 16) ? 32'h6 : 32'h2);
         step();
      end
      idle_inputs();
      step(); step();

      // Ack on the same cycle the watchdog would fire: ack wins
      {m0_cyc_i, m0_stb_i} = 2'b11;
      step();
      for (int g = 1; g <= 16; g++) begin
         s_ack_i = (g == 16);
         settle();
         chk($sformatf("race g%0d m0_ack", g), 32'(m0_ack_o), 32'(g == 16));
         chk($sformatf("race g%0d m0_err", g), 32'(m0_err_o), 32'h0);
         step();
      end
      idle_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
